// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N one-hot decoder.
// The optional parity check is enabled by defining DEC_PARITY_CHECK_EN.
package decoder_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OUT  = 1'b1
  } dec_state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  // The decode helper works on the widest supported select; callers truncate to their own width.
  localparam int DEC_MAX_SEL_W = 6;
  localparam int DEC_MAX_OUT_W = 2 ** DEC_MAX_SEL_W;

  function automatic logic [DEC_MAX_OUT_W-1:0] onehot_dec(input logic [DEC_MAX_SEL_W-1:0] sel,
                                                          input logic en);
    onehot_dec = '0;
    if (en) onehot_dec[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Pure combinational N-to-2^N one-hot decoder with enable; all-zero when disabled.
module decoder_onehot
  import decoder_pkg::*;
#(
  parameter int N_SEL = 2,
  localparam int OUT_W = 2 ** N_SEL
) (
  input  logic [N_SEL-1:0] sel,
  input  logic             en,
  output logic [OUT_W-1:0] dec
);

  if (N_SEL > DEC_MAX_SEL_W) begin : g_width_guard
    $error("decoder_onehot: N_SEL exceeds DEC_MAX_SEL_W");
  end

  assign dec = OUT_W'(onehot_dec(DEC_MAX_SEL_W'(sel), en));

endmodule

// File: rtl/decoder_n2m_pipe.sv
// Registered one-hot decoder with valid/ready flow control, LEVEL/PULSE output and a
// saturating decode counter. Define DEC_PARITY_CHECK_EN to add the in_par/par_err ports.
module decoder_n2m_pipe
  import decoder_pkg::*;
#(
  parameter int N_SEL = 2,
  parameter int CNT_W = 8,
  localparam int OUT_W = 2 ** N_SEL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_SEL-1:0] in_sel,
  input  logic             in_en,
  input  logic             mode,
`ifdef DEC_PARITY_CHECK_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_d,
  output logic [CNT_W-1:0] dec_count
);

  dec_state_t       state;
  logic [OUT_W-1:0] dec_word;
  logic             in_hs;
  logic             out_hs;
  logic             par_bad;
  logic             beat_ok;

  decoder_onehot #(.N_SEL(N_SEL)) u_onehot (
    .sel (in_sel),
    .en  (in_en),
    .dec (dec_word)
  );

  assign in_ready = !out_valid || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

`ifdef DEC_PARITY_CHECK_EN
  assign par_bad = (in_par != ^{in_en, in_sel});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= in_hs && par_bad;
  end
`else
  assign par_bad = 1'b0;
`endif

  // A beat with bad parity is still consumed upstream, it just never reaches the output.
  assign beat_ok = in_hs && !par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_d     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (beat_ok) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_d     <= dec_word;
          end
        end
        S_OUT: begin
          if (beat_ok) begin
            out_d <= dec_word;
          end else if (out_hs) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            if (mode == MODE_PULSE) out_d <= '0;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_d     <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_count <= '0;
    end else if (beat_ok && in_en && (dec_count != {CNT_W{1'b1}})) begin
      dec_count <= dec_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_n2m_pipe.sv
// Self-checking bench for decoder_n2m_pipe: vector table, scoreboard and corner sequences.
// Also exercises the parity ports when built with DEC_PARITY_CHECK_EN.
module tb_decoder_n2m_pipe;
  import decoder_pkg::*;

  localparam int N_SEL = 2;
  localparam int CNT_W = 8;
  localparam int OUT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N_SEL-1:0] in_sel;
  logic             in_en;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_d;
  logic [CNT_W-1:0] dec_count;
  logic             bad_par;
  logic             par_ok;
`ifdef DEC_PARITY_CHECK_EN
  logic             in_par;
  logic             par_err;
  assign in_par = (^{in_en, in_sel}) ^ bad_par;
`endif

  int tests  = 0;
  int failed = 0;
  logic [OUT_W-1:0] sb_q[$];

  decoder_n2m_pipe #(.N_SEL(N_SEL), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_en     (in_en),
    .mode      (mode),
`ifdef DEC_PARITY_CHECK_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .dec_count (dec_count)
  );

  always #5 clk = ~clk;

  assign par_ok = !bad_par;

  typedef struct {
    logic [N_SEL-1:0] sel;
    logic             en;
    logic [OUT_W-1:0] exp_d;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on output handshake (current word), push on accepted good beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(out_d), 32'hdead);
        end else begin
          chk("sb_out_d", 32'(out_d), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready && par_ok) begin
        logic [OUT_W-1:0] e;
        e = '0;
        if (in_en) e[in_sel] = 1'b1;
        sb_q.push_back(e);
      end
    end
  end

  initial begin
    vecs[0] = '{sel: 2'd0, en: 1'b0, exp_d: 4'b0000};
    vecs[1] = '{sel: 2'd0, en: 1'b1, exp_d: 4'b0001};
    vecs[2] = '{sel: 2'd1, en: 1'b1, exp_d: 4'b0010};
    vecs[3] = '{sel: 2'd2, en: 1'b1, exp_d: 4'b0100};
    vecs[4] = '{sel: 2'd3, en: 1'b1, exp_d: 4'b1000};

    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_en = 1'b0;
    mode = MODE_LEVEL; out_ready = 1'b1; bad_par = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_d", 32'(out_d), 0);
    chk("rst_count", 32'(dec_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Sweep en=0 then sel=0..3 back to back
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sel = vecs[i].sel; in_en = vecs[i].en;
      step();
      chk("sweep_out_d", 32'(out_d), 32'(vecs[i].exp_d));
      chk("sweep_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    step();
    chk("sweep_count", 32'(dec_count), 4);
    chk("sweep_idle", 32'(out_valid), 0);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_en = 1'b1;
    step();
    in_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_d", 32'(out_d), 32'h4);
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    step();
    chk("bp_next_d", 32'(out_d), 32'h8);
    in_valid = 1'b0;
    step();
    chk("bp_count", 32'(dec_count), 6);

    // Back-to-back, then LEVEL hold
    in_valid = 1'b1; in_sel = 2'd1;
    step();
    chk("b2b_d0", 32'(out_d), 32'h2);
    chk("b2b_v0", 32'(out_valid), 1);
    in_sel = 2'd3;
    step();
    chk("b2b_d1", 32'(out_d), 32'h8);
    chk("b2b_v1", 32'(out_valid), 1);
    in_valid = 1'b0; mode = MODE_LEVEL;
    step();
    chk("level_d", 32'(out_d), 32'h8);
    chk("level_v", 32'(out_valid), 0);

    // PULSE clears after handshake
    in_valid = 1'b1; in_sel = 2'd0;
    step();
    chk("pulse_load", 32'(out_d), 32'h1);
    in_valid = 1'b0; mode = MODE_PULSE;
    step();
    chk("pulse_d", 32'(out_d), 0);
    chk("pulse_v", 32'(out_valid), 0);
    mode = MODE_LEVEL;
    chk("pulse_count", 32'(dec_count), 9);

`ifdef DEC_PARITY_CHECK_EN
    in_valid = 1'b1; in_sel = 2'd1; in_en = 1'b1; bad_par = 1'b1;
    step();
    chk("par_err_set", 32'(par_err), 1);
    chk("par_no_out", 32'(out_valid), 0);
    in_valid = 1'b0; bad_par = 1'b0;
    step();
    chk("par_err_clr", 32'(par_err), 0);
    chk("par_count", 32'(dec_count), 9);
`endif

    // Reset mid-transfer, asynchronous
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_en = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mid_pending", 32'(out_valid), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_d", 32'(out_d), 0);
    chk("mid_rst_count", 32'(dec_count), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    sb_q.delete();
    @(negedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Counter saturation
    in_valid = 1'b1; in_en = 1'b1;
    for (int i = 0; i < 254; i++) begin
      in_sel = 2'(i);
      step();
    end
    chk("sat_254", 32'(dec_count), 254);
    for (int i = 0; i < 6; i++) begin
      in_sel = 2'(i);
      step();
    end
    chk("sat_hold", 32'(dec_count), 255);
    in_valid = 1'b0;
    step();
    step();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
